// File: rtl/fb_rect_writer.sv
// Filled-rectangle write engine for the 160x120x6 frame buffer: a small command
// FIFO feeds a clip/setup stage and a one-pixel-per-clock draw loop gated by vblank.
module fb_rect_writer #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int ADDR_W   = 15,
  parameter int FIFO_DEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [6:0]        cmd_h,
  input  logic [5:0]        cmd_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [5:0]        fb_data,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEP);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEP);
  localparam logic [8:0]        FB_W9    = 9'(FB_W);
  localparam logic [8:0]        FB_H9    = 9'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [5:0] color;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_e;

  state_e state, state_nxt;

  // Handshake: a command transfers on every rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on the FIFO fill level, and
  // the offering side must hold its fields stable until that edge.
  cmd_t             fifo_mem [FIFO_DEP];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, fifo_empty;
  cmd_t             cmd_in;

  assign cmd_ready  = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid & cmd_ready;
  assign cmd_in     = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Working copy of the command being executed, plus the clipped draw window.
  cmd_t              cur;
  logic [7:0]        cx;
  logic [6:0]        cy;
  logic [8:0]        x_end, y_end;
  logic [ADDR_W-1:0] row_base;

  logic [8:0] x_sum, y_sum, x_end_c, y_end_c;
  logic       discard, last_col, last_row, draw_step;

  assign x_sum   = {1'b0, cur.x} + {1'b0, cur.w};
  assign y_sum   = {2'b00, cur.y} + {2'b00, cur.h};
  assign x_end_c = (x_sum > FB_W9) ? FB_W9 : x_sum;
  assign y_end_c = (y_sum > FB_H9) ? FB_H9 : y_sum;
  assign discard = (cur.w == 8'd0) || (cur.h == 7'd0) ||
                   ({1'b0, cur.x} >= FB_W9) || ({2'b00, cur.y} >= FB_H9);

  assign last_col = ({1'b0, cx} == x_end - 9'd1);
  assign last_row = ({2'b00, cy} == y_end - 9'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    draw_step = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = discard ? IDLE : DRAW;
      end
      DRAW: begin
        if (vblank) begin
          draw_step = 1'b1;
          if (last_col && last_row) begin
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = SETUP;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      cx       <= '0;
      cy       <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
    end else begin
      if (pop) cur <= fifo_mem[rd_ptr];
      if (state == SETUP) begin
        cx       <= cur.x;
        cy       <= cur.y;
        x_end    <= x_end_c;
        y_end    <= y_end_c;
        // y*160 as (y<<7)+(y<<5)
        row_base <= ADDR_W'({cur.y, 7'b0}) + ADDR_W'({cur.y, 5'b0});
      end else if (draw_step) begin
        if (last_col) begin
          cx       <= cur.x;
          cy       <= cy + 7'd1;
          row_base <= row_base + FB_W_A;
        end else begin
          cx <= cx + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= draw_step;
      if (draw_step) begin
        fb_addr <= row_base + ADDR_W'(cx);
        fb_data <= cur.color;
      end
    end
  end

  assign busy      = !fifo_empty || (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: directed scenarios plus randomized commands, with
// every frame buffer write checked against a rectangle-clipping reference model.
module tb_fb_rect_writer;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x = '0;
  logic [6:0]  cmd_y = '0;
  logic [7:0]  cmd_w = '0;
  logic [6:0]  cmd_h = '0;
  logic [5:0]  cmd_color = '0;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [5:0]  fb_data;
  logic        busy;
  logic [1:0]  fsm_state;

  fb_rect_writer dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [20:0] exp_q[$];
  logic [20:0] mon_exp;
  logic        rand_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: every on-screen pixel of the rectangle, row-major order.
  task automatic model_push(input int x, input int y, input int w, input int h, input int c);
    for (int r = y; r < y + h; r++)
      if (r < FB_H)
        for (int col = x; col < x + w; col++)
          if (col < FB_W) exp_q.push_back({15'(r * FB_W + col), 6'(c)});
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_cmd(input int x, input int y, input int w, input int h, input int c);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 6'(c);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL send_timeout actual=ready_low required=accept");
    end else begin
      model_push(x, y, w, h, c);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 0);
    @(negedge clk);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (fb_we) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%0h required=no_write", fb_addr, fb_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({fb_addr, fb_data} !== mon_exp) begin
          failures++;
          $display("FAIL write actual addr=%0d data=%0h required addr=%0d data=%0h",
                   fb_addr, fb_data, mon_exp[20:6], mon_exp[5:0]);
        end
      end
    end
  end

  initial begin
    int n;
    rand_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_data", 32'(fb_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_state", 32'(fsm_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 3x2 rectangle and first-write latency
    vblank = 1'b1;
    wr_cnt = 0;
    send_cmd(10, 5, 3, 2, 'h2A);
    n = 0;
    while (!fb_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency_edges", n, 3);
    wait_idle("basic_idle");
    check("basic_count", wr_cnt, 6);
    check("basic_drain", exp_q.size(), 0);

    // vblank gap after two pixels
    wr_cnt = 0;
    send_cmd(10, 5, 3, 2, 'h2A);
    n = 0;
    while (!(fb_we && fb_addr == 15'd811) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("gap_reach_811", 32'(fb_addr), 811);
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_we_low", 32'(fb_we), 0);
    end
    vblank = 1'b1;
    wait_idle("gap_idle");
    check("gap_count", wr_cnt, 6);

    // Clipping at the bottom-right corner
    wr_cnt = 0;
    send_cmd(158, 119, 5, 4, 'h3F);
    wait_idle("clip_idle");
    check("clip_count", wr_cnt, 2);

    // Discarded commands
    wr_cnt = 0;
    send_cmd(160, 3, 4, 4, 'h11);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("discard_x_busy_within3", 32'(n <= 3), 1);
    check("discard_x_state", 32'(fsm_state), 0);
    send_cmd(7, 3, 0, 4, 'h12);
    wait_idle("discard_w_idle");
    check("discard_w_state", 32'(fsm_state), 0);
    check("discard_count", wr_cnt, 0);

    // Queueing with vblank low: one command held by the engine, four in the FIFO
    vblank = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) send_cmd(i, 0, 1, 1, i + 1);
    check("queue_full_ready", 32'(cmd_ready), 0);
    fork
      send_cmd(5, 0, 1, 1, 6);
      begin
        repeat (8) @(negedge clk);
        check("queue_stall_ready", 32'(cmd_ready), 0);
        check("queue_stall_we", 32'(fb_we), 0);
        vblank = 1'b1;
      end
    join
    wait_idle("queue_idle");
    check("queue_count", wr_cnt, 6);
    check("queue_ready_back", 32'(cmd_ready), 1);

    // Reset in the middle of a full-screen fill
    send_cmd(0, 0, 160, 120, 'h15);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstdraw_we", 32'(fb_we), 0);
    check("rstdraw_busy", 32'(busy), 0);
    check("rstdraw_ready", 32'(cmd_ready), 1);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    wr_cnt = 0;
    send_cmd(0, 0, 1, 1, 'h09);
    wait_idle("rstdraw_idle");
    check("rstdraw_count", wr_cnt, 1);

    // Randomized commands with random vblank toggling
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 7) == 0)
            send_cmd($urandom_range(140, 200), $urandom_range(100, 127),
                     $urandom_range(0, 40), $urandom_range(0, 20), $urandom_range(0, 63));
          else
            send_cmd($urandom_range(0, 170), $urandom_range(0, 125),
                     $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 63));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) vblank = ~vblank;
        end
      end
    join
    vblank = 1'b1;
    wait_idle("rand_idle");
    check("rand_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
